// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART image loader
//
// Contents:
//   state_t            loader FSM states (ST_CHECK only with UART_LOADER_CHECKSUM_EN)
//   ERR_NONE..ERR_CSUM 2-bit error codes reported on err_code_o
//   DEFAULT_SYNC_BYTE  frame start marker
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SYNC,
        ST_HDR_W,
        ST_HDR_H,
`ifdef UART_LOADER_CHECKSUM_EN
        ST_PAYLOAD,
        ST_CHECK
`else
        ST_PAYLOAD
`endif
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HDR     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_idle_timer.sv
// rtl/loader_idle_timer.sv - inter-byte idle counter with one-cycle expire strobe
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          restart the count (a byte arrived)
//   en           count this cycle; count is held at 0 while low
//   expire       high for the single cycle in which TIMEOUT_CYCLES idle cycles elapse
module loader_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of idle cycles already completed; the cycle that
    // completes the TIMEOUT_CYCLES-th one raises expire.
    assign expire = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// rtl/uart_image_loader.sv - parses sync/W/H/pixel frames from uart_rx into image BRAM
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   byte_i, byte_valid_i    received byte and its 1-cycle strobe
//   arm_i                   start waiting for a frame (ignored while busy)
//   abort_i                 drop the current frame without error
//   busy_o                  high outside IDLE
//   done_o                  1-cycle pulse, frame stored
//   err_o, err_code_o       sticky error and its code, cleared by arm_i
//   width_o, height_o       latched frame dimensions
//   bram_we_o/addr_o/data_o pixel write port, raster order
module uart_image_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    input  logic              arm_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [7:0]        width_o,
    output logic [7:0]        height_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [7:0]        bram_data_o
);

    localparam logic [ADDR_W:0] MAX_PIX = (ADDR_W+1)'(1) << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] pix_last;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic [15:0]       hdr_prod;
    logic [ADDR_W:0]   hdr_prod_ext;
    logic              hdr_bad;
    logic              tmr_en;
    logic              tmr_expire;

    // Height byte is on byte_i while width is already latched.
    assign hdr_prod     = {8'h00, width_o} * {8'h00, byte_i};
    assign hdr_prod_ext = (ADDR_W+1)'(hdr_prod);
    assign hdr_bad      = (width_o == 8'd0) || (byte_i == 8'd0) || (hdr_prod_ext > MAX_PIX);

    assign busy_o = (state != ST_IDLE);
    assign tmr_en = busy_o && (state != ST_WAIT_SYNC);

    loader_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (byte_valid_i),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            width_o     <= 8'd0;
            height_o    <= 8'd0;
            bram_we_o   <= 1'b0;
            bram_addr_o <= '0;
            bram_data_o <= 8'd0;
            pix_idx     <= '0;
            pix_last    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum        <= 8'd0;
`endif
        end else begin
            bram_we_o <= 1'b0;
            done_o    <= 1'b0;

            if (abort_i && state != ST_IDLE) begin
                state <= ST_IDLE;
            end else if (tmr_expire) begin
                state      <= ST_IDLE;
                err_o      <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
            end else if (state == ST_IDLE) begin
                // Bytes are ignored here, so arm_i is the only event that matters.
                if (arm_i) begin
                    state      <= ST_WAIT_SYNC;
                    err_o      <= 1'b0;
                    err_code_o <= ERR_NONE;
                end
            end else if (byte_valid_i) begin
                case (state)
                    ST_WAIT_SYNC: begin
                        if (byte_i == SYNC_BYTE) begin
                            state <= ST_HDR_W;
`ifdef UART_LOADER_CHECKSUM_EN
                            csum  <= 8'd0;
`endif
                        end
                    end
                    ST_HDR_W: begin
                        width_o <= byte_i;
                        state   <= ST_HDR_H;
                    end
                    ST_HDR_H: begin
                        height_o <= byte_i;
                        pix_idx  <= '0;
                        if (hdr_bad) begin
                            state      <= ST_IDLE;
                            err_o      <= 1'b1;
                            err_code_o <= ERR_HDR;
                        end else begin
                            state    <= ST_PAYLOAD;
                            pix_last <= ADDR_W'(hdr_prod_ext - 1'b1);
                        end
                    end
                    ST_PAYLOAD: begin
                        bram_we_o   <= 1'b1;
                        bram_addr_o <= pix_idx;
                        bram_data_o <= byte_i;
                        pix_idx     <= pix_idx + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum        <= csum ^ byte_i;
                        if (pix_idx == pix_last) begin
                            state <= ST_CHECK;
                        end
`else
                        if (pix_idx == pix_last) begin
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end
`endif
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        state <= ST_IDLE;
                        if (byte_i == csum) begin
                            done_o <= 1'b1;
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_CSUM;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_image_loader.sv
// tb/tb_uart_image_loader.sv - directed self-checking bench for uart_image_loader
module tb_uart_image_loader;

    localparam int AW  = 16;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_i = 8'd0;
    logic          byte_valid_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic [7:0]    width_o;
    logic [7:0]    height_o;
    logic          bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [7:0]    bram_data_o;

    always #5 clk = ~clk;

    uart_image_loader #(
        .ADDR_W        (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .bram_we_o    (bram_we_o),
        .bram_addr_o  (bram_addr_o),
        .bram_data_o  (bram_data_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] wq[$];
    int          done_cnt = 0;
    logic [31:0] done_addr = 0;
    logic [31:0] done_we = 0;

    always @(negedge clk) begin
        if (bram_we_o) wq.push_back({bram_addr_o, bram_data_o});
        if (done_o) begin
            done_cnt  = done_cnt + 1;
            done_addr = 32'(bram_addr_o);
            done_we   = 32'(bram_we_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk);
        arm_i = 1'b1;
        @(negedge clk);
        arm_i = 1'b0;
    endtask

    task automatic abort();
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_we", 32'(bram_we_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_width", 32'(width_o), 0);
        rst_n = 1'b1;

        // 1: 4x2 frame
        clear_log();
        arm();
        send(8'hA5); send(8'h04); send(8'h02);
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
        @(negedge clk);
        chk("t1_nwr", 32'(wq.size()), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            chk("t1_addr", 32'(wq[i][23:8]), i);
            chk("t1_data", 32'(wq[i][7:0]), 'h10 + i);
        end
        chk("t1_done", done_cnt, 1);
        chk("t1_done_addr", done_addr, 7);
        chk("t1_done_we", done_we, 1);
        chk("t1_width", 32'(width_o), 4);
        chk("t1_height", 32'(height_o), 2);
        chk("t1_busy", 32'(busy_o), 0);
        chk("t1_err", 32'(err_o), 0);

        // 2: junk before sync, 1x1 frame
        clear_log();
        arm();
        send(8'h33); send(8'hA5); send(8'h01); send(8'h01); send(8'h55);
        @(negedge clk);
        chk("t2_nwr", 32'(wq.size()), 1);
        if (wq.size() > 0) chk("t2_wr", 32'(wq[0]), 32'h000055);
        chk("t2_done", done_cnt, 1);
        chk("t2_busy", 32'(busy_o), 0);

        // 3: zero width header
        clear_log();
        arm();
        send(8'hA5); send(8'h00); send(8'h05);
        @(negedge clk);
        chk("t3_err", 32'(err_o), 1);
        chk("t3_code", 32'(err_code_o), 1);
        chk("t3_nwr", 32'(wq.size()), 0);
        chk("t3_busy", 32'(busy_o), 0);
        chk("t3_done", done_cnt, 0);
        abort();
        chk("t3_abort_idle_err", 32'(err_o), 1);
        chk("t3_abort_idle_code", 32'(err_code_o), 1);

        // 4: timeout mid-payload
        clear_log();
        arm();
        chk("t4_arm_clr", 32'(err_o), 0);
        send(8'hA5); send(8'h02); send(8'h02); send(8'h20); send(8'h21);
        repeat (TMO - 1) @(negedge clk);
        chk("t4_pre_err", 32'(err_o), 0);
        chk("t4_pre_busy", 32'(busy_o), 1);
        @(negedge clk);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_code", 32'(err_code_o), 2);
        chk("t4_busy", 32'(busy_o), 0);
        chk("t4_nwr", 32'(wq.size()), 2);
        chk("t4_done", done_cnt, 0);
        arm();
        chk("t4_rearm_err", 32'(err_o), 0);
        chk("t4_rearm_code", 32'(err_code_o), 0);
        abort();
        chk("t4_abort_busy", 32'(busy_o), 0);

        // 5: checksum trailer
`ifdef UART_LOADER_CHECKSUM_EN
        clear_log();
        arm();
        send(8'hA5); send(8'h02); send(8'h01); send(8'h0F); send(8'hF0);
        chk("t5_check_busy", 32'(busy_o), 1);
        send(8'hFF);
        @(negedge clk);
        chk("t5_nwr", 32'(wq.size()), 2);
        chk("t5_done", done_cnt, 1);
        chk("t5_err", 32'(err_o), 0);
        chk("t5_busy", 32'(busy_o), 0);
        clear_log();
        arm();
        send(8'hA5); send(8'h02); send(8'h01); send(8'h0F); send(8'hF0); send(8'h00);
        @(negedge clk);
        chk("t5b_err", 32'(err_o), 1);
        chk("t5b_code", 32'(err_code_o), 3);
        chk("t5b_done", done_cnt, 0);
        chk("t5b_nwr", 32'(wq.size()), 2);
`else
        clear_log();
        arm();
        send(8'hA5); send(8'h02); send(8'h01); send(8'h0F); send(8'hF0);
        @(negedge clk);
        chk("t5_done", done_cnt, 1);
        chk("t5_busy", 32'(busy_o), 0);
        send(8'hFF);
        @(negedge clk);
        chk("t5_nwr", 32'(wq.size()), 2);
        chk("t5_err", 32'(err_o), 0);
`endif

        // 6a: abort mid-payload
        clear_log();
        arm();
        send(8'hA5); send(8'h04); send(8'h02); send(8'h01); send(8'h02); send(8'h03);
        abort();
        send(8'h04); send(8'h05);
        @(negedge clk);
        chk("t6a_nwr", 32'(wq.size()), 3);
        chk("t6a_busy", 32'(busy_o), 0);
        chk("t6a_err", 32'(err_o), 0);
        chk("t6a_done", done_cnt, 0);

        // 6b: asynchronous reset right after a pixel write
        arm();
        send(8'hA5); send(8'h04); send(8'h02); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #1;
        chk("t6b_we", 32'(bram_we_o), 0);
        chk("t6b_addr", 32'(bram_addr_o), 0);
        chk("t6b_busy", 32'(busy_o), 0);
        chk("t6b_width", 32'(width_o), 0);
        chk("t6b_err", 32'(err_o), 0);
        clear_log();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h03); send(8'h04);
        @(negedge clk);
        chk("t6b_nwr", 32'(wq.size()), 0);
        chk("t6b_idle", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
